cnt_monitor: RTL and testbench

- Downstream observer of the loadable 8-bit counter stage. Samples the counter output CNT and the counter enable ENA every CLOCK.
- Flags four conditions: threshold match, natural wrap-around (all-ones to zero), stall (enabled but not advancing), and per-cycle count delta.
- Keeps a saturating wrap-event counter for the status/test logic.

---
 rtl/cnt_monitor.sv | 157 +++++++++++++++
 tb/tb_cnt_monitor.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnt_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : cnt_monitor
//  Description : Observer for a loadable counter stage. Flags threshold entry,
//                natural wrap-around, stalls (enabled but not advancing) and
//                reports the per-cycle count delta plus a saturating wrap tally.
//  Revision    : 1.0 - initial release
// ============================================================================
module cnt_monitor #(
    parameter int WIDTH       = 8,
    parameter int EVT_W       = 8,
    parameter int STALL_LIMIT = 16
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] CNT,
    input  logic             ENA,
    input  logic [WIDTH-1:0] THRESH,
    input  logic             CLR,
    output logic             MATCH,
    output logic             WRAP,
    output logic             STALL,
    output logic [WIDTH-1:0] DELTA,
    output logic [EVT_W-1:0] WRAP_CNT,
    output logic [1:0]       STATE
);

    localparam int               SC_W      = $clog2(STALL_LIMIT + 1);
    localparam logic [SC_W-1:0]  STALL_MAX = SC_W'(STALL_LIMIT);
    localparam logic [SC_W-1:0]  SC_ONE    = SC_W'(1);
    localparam logic [EVT_W-1:0] EVT_MAX   = '1;
    localparam logic [EVT_W-1:0] EVT_ONE   = EVT_W'(1);
    localparam logic [WIDTH-1:0] ALL_ONES  = '1;
    localparam logic [WIDTH-1:0] ZERO      = '0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_TRACK   = 2'b01,
        ST_STALLED = 2'b10
    } state_t;

    state_t           state_q,     state_d;
    logic [WIDTH-1:0] prev_q,      prev_d;
    logic [WIDTH-1:0] thresh_q,    thresh_d;
    logic [WIDTH-1:0] delta_q,     delta_d;
    logic             match_q,     match_d;
    logic             wrap_q,      wrap_d;
    logic [EVT_W-1:0] wrap_cnt_q,  wrap_cnt_d;
    logic [SC_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic cnt_same;
    logic cnt_hits_thresh;
    logic match_entry;
    logic wrap_event;

    // Event decode against the previous sample. A threshold change that lands
    // on the current count is treated as a fresh entry even if prev already
    // equals the new threshold.
    always_comb begin
        cnt_same        = (CNT == prev_q);
        cnt_hits_thresh = (CNT == THRESH);
        match_entry     = cnt_hits_thresh && ((prev_q != THRESH) || (THRESH != thresh_q));
        wrap_event      = (prev_q == ALL_ONES) && (CNT == ZERO);
    end

    // Next-state and output computation; CLR overrides every event.
    always_comb begin
        state_d     = state_q;
        prev_d      = CNT;
        thresh_d    = THRESH;
        delta_d     = delta_q;
        match_d     = 1'b0;
        wrap_d      = 1'b0;
        wrap_cnt_d  = wrap_cnt_q;
        stall_cnt_d = stall_cnt_q;

        if (CLR) begin
            state_d     = ST_IDLE;
            delta_d     = '0;
            wrap_cnt_d  = '0;
            stall_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // First sample only primes prev; nothing is reported yet.
                    state_d     = ST_TRACK;
                    delta_d     = '0;
                    stall_cnt_d = '0;
                end
                ST_TRACK, ST_STALLED: begin
                    delta_d = CNT - prev_q;
                    match_d = match_entry;
                    wrap_d  = wrap_event;
                    if (wrap_event && (wrap_cnt_q != EVT_MAX)) begin
                        wrap_cnt_d = wrap_cnt_q + EVT_ONE;
                    end

                    if (ENA && cnt_same) begin
                        if (stall_cnt_q != STALL_MAX) begin
                            stall_cnt_d = stall_cnt_q + SC_ONE;
                        end
                    end else begin
                        stall_cnt_d = '0;
                    end

                    if (state_q == ST_STALLED) begin
                        if (!(ENA && cnt_same)) begin
                            state_d = ST_TRACK;
                        end
                    end else if (stall_cnt_d == STALL_MAX) begin
                        state_d = ST_STALLED;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    delta_d     = '0;
                    stall_cnt_d = '0;
                end
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= ST_IDLE;
            prev_q      <= '0;
            thresh_q    <= '0;
            delta_q     <= '0;
            match_q     <= 1'b0;
            wrap_q      <= 1'b0;
            wrap_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            thresh_q    <= thresh_d;
            delta_q     <= delta_d;
            match_q     <= match_d;
            wrap_q      <= wrap_d;
            wrap_cnt_q  <= wrap_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Outputs come straight from registers; STALL is a decode of the state flop.
    always_comb begin
        MATCH    = match_q;
        WRAP     = wrap_q;
        STALL    = (state_q == ST_STALLED);
        DELTA    = delta_q;
        WRAP_CNT = wrap_cnt_q;
        STATE    = state_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_cnt_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cnt_monitor
//  Description : Directed self-checking bench for cnt_monitor (EVT_W=2 so the
//                wrap tally saturates quickly).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cnt_monitor;

    logic       CLOCK = 1'b0;
    logic       RESET = 1'b0;
    logic [7:0] CNT = 8'd0;
    logic       ENA = 1'b0;
    logic [7:0] THRESH = 8'd5;
    logic       CLR = 1'b0;
    logic       MATCH;
    logic       WRAP;
    logic       STALL;
    logic [7:0] DELTA;
    logic [1:0] WRAP_CNT;
    logic [1:0] STATE;

    int n_vec = 0;
    int n_err = 0;

    // Packed view: {STATE, STALL, MATCH, WRAP, DELTA, WRAP_CNT}
    logic [14:0] obs;
    assign obs = {STATE, STALL, MATCH, WRAP, DELTA, WRAP_CNT};

    cnt_monitor #(
        .WIDTH(8),
        .EVT_W(2),
        .STALL_LIMIT(16)
    ) dut (
        .CLOCK(CLOCK),
        .RESET(RESET),
        .CNT(CNT),
        .ENA(ENA),
        .THRESH(THRESH),
        .CLR(CLR),
        .MATCH(MATCH),
        .WRAP(WRAP),
        .STALL(STALL),
        .DELTA(DELTA),
        .WRAP_CNT(WRAP_CNT),
        .STATE(STATE)
    );

    always #5 CLOCK = ~CLOCK;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic test_reset();
        logic [14:0] exp;
        RESET = 1'b0;
        tick();
        tick();
        exp = {2'b00, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0};
        n_vec++;
        if (obs !== exp) begin
            $display("FAIL reset_state actual=%h required=%h", obs, exp);
            n_err++;
        end
        RESET = 1'b1;
    endtask

    task automatic test_counting();
        logic [14:0] exp;
        THRESH = 8'd5;
        ENA    = 1'b1;
        CNT    = 8'd0;
        tick();
        exp = {2'b01, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0};
        n_vec++;
        if (obs !== exp) begin
            $display("FAIL count_first_edge actual=%h required=%h", obs, exp);
            n_err++;
        end
        for (int i = 1; i <= 9; i++) begin
            CNT = 8'(i);
            tick();
            exp = {2'b01, 1'b0, (i == 5), 1'b0, 8'd1, 2'd0};
            n_vec++;
            if (obs !== exp) begin
                $display("FAIL count_step_%0d actual=%h required=%h", i, obs, exp);
                n_err++;
            end
        end
    endtask

    task automatic test_wrap();
        logic [7:0]  seq   [7] = '{8'd253, 8'd254, 8'd255, 8'd0, 8'd1, 8'd200, 8'd0};
        logic [7:0]  dlt   [7] = '{8'd244, 8'd1, 8'd1, 8'd1, 8'd1, 8'd199, 8'd56};
        logic        mt    [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic        wr    [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [1:0]  wc    [7] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1};
        logic [14:0] exp;
        THRESH = 8'd0;
        for (int i = 0; i < 7; i++) begin
            CNT = seq[i];
            tick();
            exp = {2'b01, 1'b0, mt[i], wr[i], dlt[i], wc[i]};
            n_vec++;
            if (obs !== exp) begin
                $display("FAIL wrap_step_%0d cnt=%0d actual=%h required=%h", i, seq[i], obs, exp);
                n_err++;
            end
        end
    endtask

    task automatic test_stall();
        logic [14:0] exp;
        THRESH = 8'd100;
        ENA    = 1'b1;
        CNT    = 8'd7;
        tick();
        exp = {2'b01, 1'b0, 1'b0, 1'b0, 8'd7, 2'd1};
        n_vec++;
        if (obs !== exp) begin
            $display("FAIL stall_enter7 actual=%h required=%h", obs, exp);
            n_err++;
        end
        for (int k = 1; k <= 20; k++) begin
            tick();
            exp = {(k >= 16) ? 2'b10 : 2'b01, (k >= 16), 1'b0, 1'b0, 8'd0, 2'd1};
            n_vec++;
            if (obs !== exp) begin
                $display("FAIL stall_hold_%0d actual=%h required=%h", k, obs, exp);
                n_err++;
            end
        end
        CNT = 8'd8;
        tick();
        exp = {2'b01, 1'b0, 1'b0, 1'b0, 8'd1, 2'd1};
        n_vec++;
        if (obs !== exp) begin
            $display("FAIL stall_exit actual=%h required=%h", obs, exp);
            n_err++;
        end
        ENA = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            exp = {2'b01, 1'b0, 1'b0, 1'b0, 8'd0, 2'd1};
            n_vec++;
            if (obs !== exp) begin
                $display("FAIL stall_noena_%0d actual=%h required=%h", k, obs, exp);
                n_err++;
            end
        end
    endtask

    task automatic test_async_reset();
        logic [14:0] exp;
        ENA = 1'b1;
        CNT = 8'd8;
        for (int k = 1; k <= 17; k++) tick();
        exp = {2'b10, 1'b1, 1'b0, 1'b0, 8'd0, 2'd1};
        n_vec++;
        if (obs !== exp) begin
            $display("FAIL areset_pre_stalled actual=%h required=%h", obs, exp);
            n_err++;
        end
        #3 RESET = 1'b0;
        #1;
        exp = {2'b00, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0};
        n_vec++;
        if (obs !== exp) begin
            $display("FAIL areset_immediate actual=%h required=%h", obs, exp);
            n_err++;
        end
        #1 RESET = 1'b1;
        #1;
        n_vec++;
        if (obs !== exp) begin
            $display("FAIL areset_released actual=%h required=%h", obs, exp);
            n_err++;
        end
        CNT = 8'd20;
        tick();
        exp = {2'b01, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0};
        n_vec++;
        if (obs !== exp) begin
            $display("FAIL areset_idle_edge actual=%h required=%h", obs, exp);
            n_err++;
        end
        CNT = 8'd21;
        tick();
        exp = {2'b01, 1'b0, 1'b0, 1'b0, 8'd1, 2'd0};
        n_vec++;
        if (obs !== exp) begin
            $display("FAIL areset_resume actual=%h required=%h", obs, exp);
            n_err++;
        end
    endtask

    task automatic test_saturation_clear();
        logic [14:0] exp;
        logic [1:0]  wc_before;
        logic [1:0]  wc_after;
        logic [7:0]  d_up;
        THRESH = 8'd100;
        ENA    = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            wc_before = (k - 1 > 3) ? 2'd3 : 2'(k - 1);
            wc_after  = (k > 3) ? 2'd3 : 2'(k);
            d_up      = (k == 1) ? 8'd234 : 8'd255;
            CNT = 8'd255;
            tick();
            exp = {2'b01, 1'b0, 1'b0, 1'b0, d_up, wc_before};
            n_vec++;
            if (obs !== exp) begin
                $display("FAIL sat_top_%0d actual=%h required=%h", k, obs, exp);
                n_err++;
            end
            CNT = 8'd0;
            tick();
            exp = {2'b01, 1'b0, 1'b0, 1'b1, 8'd1, wc_after};
            n_vec++;
            if (obs !== exp) begin
                $display("FAIL sat_wrap_%0d actual=%h required=%h", k, obs, exp);
                n_err++;
            end
        end
        CNT = 8'd255;
        tick();
        CNT = 8'd0;
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        exp = {2'b00, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0};
        n_vec++;
        if (obs !== exp) begin
            $display("FAIL clr_on_wrap actual=%h required=%h", obs, exp);
            n_err++;
        end
    endtask

    task automatic test_thresh_change();
        logic [14:0] exp;
        ENA    = 1'b0;
        CNT    = 8'd40;
        THRESH = 8'd100;
        tick();
        tick();
        exp = {2'b01, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0};
        n_vec++;
        if (obs !== exp) begin
            $display("FAIL thr_steady actual=%h required=%h", obs, exp);
            n_err++;
        end
        THRESH = 8'd40;
        tick();
        exp = {2'b01, 1'b0, 1'b1, 1'b0, 8'd0, 2'd0};
        n_vec++;
        if (obs !== exp) begin
            $display("FAIL thr_change_pulse actual=%h required=%h", obs, exp);
            n_err++;
        end
        tick();
        exp = {2'b01, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0};
        n_vec++;
        if (obs !== exp) begin
            $display("FAIL thr_single_pulse actual=%h required=%h", obs, exp);
            n_err++;
        end
    endtask

    initial begin
        test_reset();
        test_counting();
        test_wrap();
        test_stall();
        test_async_reset();
        test_saturation_clear();
        test_thresh_change();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
